bg_tile_fetcher: RTL and testbench
==================================

Name: bg_tile_fetcher

Overview:
- Background tile fetcher for the pGB pixel pipeline.
- Reads tile map and tile pattern bytes out of VRAM (0x8000-0x9FFF) that the CPU wrote through the MMU, and decodes them into 2-bit pixels.
- Delivers exactly 160 pixels per scanline to the LCD output stage over a valid/ready handshake.
- Sits between the VRAM read port (arbitrated in the MMU) and the LCD pixel output stage.

Parameters:
- FIFO_DEPTH, 16, pixel FIFO entries. Power of two, minimum 16.
- LINE_PIXELS, 160, pixels emitted per line.

Ports:
- iClock  in  1  system clock.
- iReset  in  1  asynchronous, active-low reset.
- iStart  in  1  one-cycle pulse that starts a line. Ignored while oBusy=1.
- iLy  in  8  current scanline, sampled on iStart.
- iScx  in  8  horizontal scroll, sampled on iStart.
- iScy  in  8  vertical scroll, sampled on iStart.
- iLcdc  in  8  LCDC register, sampled on iStart. Bit0 = BG enable, bit3 = map select, bit4 = tile data select.
- iBgp  in  8  BGP palette register. Used only with the optional feature.
- oVramAddr  out  13  VRAM byte offset from 0x8000.
- oVramRe  out  1  VRAM read request.
- iVramData  in  8  read data, valid when iVramAck=1.
- iVramAck  in  1  read completion.
- oPixel  out  2  pixel colour.
- oPixelValid  out  1  pixel available.
- iPixelReady  in  1  consumer accepts the pixel.
- oBusy  out  1  line in progress.
- oLineDone  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, FIFO empty, counters cleared. Reset is honoured at any point, including mid-line or mid-VRAM-read; the outstanding request is dropped.
- On iStart in IDLE: latch the inputs and set oBusy the next cycle.
  - Y = (iLy + iScy) mod 256.
  - col = iScx[7:3].
  - discard = iScx[2:0].
- FSM states: IDLE -> MAP -> LO -> HI -> PUSH -> MAP ... -> DRAIN -> IDLE.
  - MAP: address = (iLcdc[3] ? 0x1C00 : 0x1800) + Y[7:3]*32 + col.
  - LO: address = tile base + Y[2:0]*2.
    - iLcdc[4]=1: tile base = tile*16.
    - iLcdc[4]=0: tile base = 0x1000 + signed(tile)*16, giving the range 0x0800-0x17FF.
  - HI: LO address + 1.
- VRAM handshake:
  - In MAP, LO and HI, oVramRe=1 and oVramAddr is held stable until the cycle iVramAck=1.
  - Data is captured on that ack cycle and the FSM advances on the next edge.
  - Ack in the same cycle as the request is legal (zero wait).
  - Ack while oVramRe=0 is ignored.
- PUSH:
  - Waits until FIFO free entries >= 8, then writes 8 pixels in one cycle. Pixel k (k=0..7) = {hi[7-k], lo[7-k]}.
  - col = (col+1) mod 32, wrapping the map row.
  - Returns to MAP if fewer than 160+discard pixels have been pushed, otherwise goes to DRAIN.
- Discard: the first `discard` pixels popped from the FIFO are dropped internally, one per cycle, and never presented on oPixel.
- Output:
  - oPixelValid = FIFO not empty AND the discard count has reached 0.
  - A pop occurs when oPixelValid && iPixelReady.
  - oPixel must be held stable while valid and not ready.
- DRAIN: after 160 accepted pixels, oLineDone pulses for one cycle, oBusy drops in the same cycle, the FSM goes to IDLE and the FIFO is flushed.
- BG disabled (latched iLcdc[0]=0): no VRAM reads. 160 pixels of value 0 are pushed 8 at a time; discard is forced to 0.
- Push and pop in the same cycle are allowed; the occupancy update is net.
- The 21st tile fetch happens only when discard>0. It stops as soon as 160+discard pixels have been pushed.

Optional Feature:
- BG_PALETTE_EN defined: oPixel = iBgp[2*idx+1 : 2*idx], where idx is the decoded colour index. iBgp is sampled at pop time.
- Undefined: oPixel = raw index and iBgp is unused.

Decomposition:
- Shared definitions header ppu_definitions.v holds:
  - FSM state encodings;
  - LCDC bit indices (BG_EN=0, MAP_SEL=3, TILE_SEL=4);
  - VRAM offsets 0x1800, 0x1C00 and 0x1000;
  - the 160-pixel line width.
- One sub-module: ppu_pixel_fifo. It has 2-bit entries, an 8-wide parallel write, a single-entry read, and full, empty and free-count outputs.

Test Plan:
- LCDC=0x91, SCX=SCY=LY=0, map byte at 0x9800 = 0x01, tile 1 bytes at 0x8010/0x8011 = 0xF0/0xCC -> first 8 pixels 3,3,1,1,2,2,0,0. The read order is 0x1800, 0x0010, 0x0011.
- LCDC=0x81 (signed mode), map byte 0x80, fine row 2 -> LO address 0x0804, HI address 0x0805.
- SCX=0x03, SCY=0x08, LY=0 -> first read at 0x1820. Exactly 160 pixels are emitted, the first being tile pixel 3. 21 tile fetches occur. SCX=0xF8 -> the column wraps from 31 to 0.
- Random iPixelReady stalls plus 0-3 cycle ack latency -> the pixel sequence matches a golden model, oPixel is stable under stall, and no FIFO overflow occurs.
- LCDC=0x80 -> 160 zero pixels, no oVramRe asserted, one oLineDone pulse. iStart while busy is ignored.
- iReset low mid-HI-wait -> all outputs 0 at once. A subsequent iStart produces a correct full line. With BG_PALETTE_EN and BGP=0xE4, indices 3,2,1,0 map to 3,2,1,0; with BGP=0x1B they map to 0,1,2,3.

Source files
------------

// File: rtl/bg_tile_fetcher_pkg.sv
// Shared definitions for the background tile fetcher: FSM states, LCDC bit
// indices, VRAM offsets, line width and the tile-row decode helper.
package bg_tile_fetcher_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMap,
        StLo,
        StHi,
        StPush,
        StDrain
    } fetch_state_e;

    // LCDC bit indices
    localparam int unsigned LcdcBgEn    = 0;
    localparam int unsigned LcdcMapSel  = 3;
    localparam int unsigned LcdcTileSel = 4;

    // VRAM byte offsets relative to 0x8000
    localparam logic [12:0] MapBase0       = 13'h1800;
    localparam logic [12:0] MapBase1       = 13'h1C00;
    localparam logic [12:0] TileBaseSigned = 13'h1000;

    localparam int unsigned LinePixelsDefault = 160;

    // Pixel k of a tile row sits at bits [2k+1:2k]; leftmost pixel is the byte MSB.
    function automatic logic [15:0] decode_row(input logic [7:0] lo, input logic [7:0] hi);
        logic [15:0] row;
        row = '0;
        for (int k = 0; k < 8; k++) begin
            row[2*k +: 2] = {hi[7-k], lo[7-k]};
        end
        return row;
    endfunction

endpackage

// File: rtl/ppu_pixel_fifo.sv
// Pixel FIFO with 2-bit entries: 8-wide parallel write, single-entry read,
// synchronous flush. A write is dropped if fewer than 8 entries are free.
module ppu_pixel_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     iClock,
    input  logic                     iReset,
    input  logic                     iFlush,
    input  logic                     iWrite,
    input  logic [15:0]              iWdata,
    input  logic                     iRead,
    output logic [1:0]               oRdata,
    output logic                     oFull,
    output logic                     oEmpty,
    output logic [$clog2(DEPTH):0]   oFree
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [1:0]      mem_q [DEPTH];
    logic [1:0]      mem_d [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic            do_write;
    logic            do_read;

    assign oRdata = mem_q[rd_ptr_q];
    assign oEmpty = (count_q == '0);
    assign oFull  = (count_q == (PtrW+1)'(DEPTH));
    assign oFree  = (PtrW+1)'(DEPTH) - count_q;

    // Next-state: parallel write, single pop, net occupancy update, flush wins.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_write = iWrite && (oFree >= (PtrW+1)'(8));
        do_read  = iRead && !oEmpty;
        if (do_write) begin
            for (int k = 0; k < 8; k++) begin
                mem_d[wr_ptr_q + PtrW'(k)] = iWdata[2*k +: 2];
            end
            wr_ptr_d = wr_ptr_q + PtrW'(8);
        end
        if (do_read) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        count_d = count_q + (do_write ? (PtrW+1)'(8) : '0) - (do_read ? (PtrW+1)'(1) : '0);
        if (iFlush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bg_tile_fetcher.sv
// Background tile fetcher: reads map/pattern bytes from VRAM, decodes 8 pixels
// per tile into a pixel FIFO and streams one scanline over valid/ready.
// Optional feature macro: BG_PALETTE_EN (maps colour index through iBgp at pop).
module bg_tile_fetcher
    import bg_tile_fetcher_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned LINE_PIXELS = LinePixelsDefault
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iStart,
    input  logic [7:0]  iLy,
    input  logic [7:0]  iScx,
    input  logic [7:0]  iScy,
    input  logic [7:0]  iLcdc,
    input  logic [7:0]  iBgp,
    output logic [12:0] oVramAddr,
    output logic        oVramRe,
    input  logic [7:0]  iVramData,
    input  logic        iVramAck,
    output logic [1:0]  oPixel,
    output logic        oPixelValid,
    input  logic        iPixelReady,
    output logic        oBusy,
    output logic        oLineDone
);

    localparam int unsigned FreeW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [8:0]  LinePix = 9'(LINE_PIXELS);

    fetch_state_e state_q, state_d;
    logic [7:0]   y_q, y_d;
    logic [4:0]   col_q, col_d;
    logic [2:0]   disc_total_q, disc_total_d;
    logic [2:0]   disc_cnt_q, disc_cnt_d;
    logic         bg_en_q, bg_en_d;
    logic         map_sel_q, map_sel_d;
    logic         tile_sel_q, tile_sel_d;
    logic [7:0]   tile_q, tile_d;
    logic [7:0]   lo_q, lo_d;
    logic [7:0]   hi_q, hi_d;
    logic [8:0]   pushed_q, pushed_d;
    logic [8:0]   accepted_q, accepted_d;

    logic             fifo_write;
    logic             fifo_flush;
    logic             fifo_read;
    logic [1:0]       fifo_rdata;
    logic             fifo_empty;
    logic             unused_fifo_full;
    logic [FreeW-1:0] fifo_free;
    logic [15:0]      fifo_wdata;

    logic [12:0] map_addr;
    logic [12:0] tile_base;
    logic [12:0] lo_addr;
    logic        drop;
    logic        line_end;
    logic [8:0]  pushed_next;

    // VRAM addresses for the current fetch step.
    always_comb begin
        map_addr  = (map_sel_q ? MapBase1 : MapBase0) + {3'b000, y_q[7:3], col_q};
        // Signed mode: tile number is a signed offset around 0x1000.
        tile_base = tile_sel_q ? {1'b0, tile_q, 4'b0000}
                               : TileBaseSigned + {tile_q[7], tile_q, 4'b0000};
        lo_addr   = tile_base + {9'd0, y_q[2:0], 1'b0};
    end

    // Pop side: discarded pixels drain internally before anything is presented.
    always_comb begin
        line_end    = (state_q == StDrain) && (accepted_q == LinePix);
        drop        = !fifo_empty && (disc_cnt_q != 3'd0);
        oPixelValid = (state_q != StIdle) && !fifo_empty && (disc_cnt_q == 3'd0)
                      && (accepted_q != LinePix);
        fifo_read   = (oPixelValid && iPixelReady) || drop;
        oLineDone   = line_end;
        oBusy       = (state_q != StIdle) && !line_end;
        fifo_wdata  = bg_en_q ? decode_row(lo_q, hi_q) : 16'h0000;
    end

`ifdef BG_PALETTE_EN
    // Palette lookup on the pixel currently at the FIFO head.
    assign oPixel = iBgp[{fifo_rdata, 1'b0} +: 2];
`else
    logic unused_bgp;
    assign unused_bgp = ^iBgp;
    assign oPixel     = fifo_rdata;
`endif

    // Fetch FSM next-state, VRAM request and counter updates.
    always_comb begin
        state_d      = state_q;
        y_d          = y_q;
        col_d        = col_q;
        disc_total_d = disc_total_q;
        disc_cnt_d   = disc_cnt_q;
        bg_en_d      = bg_en_q;
        map_sel_d    = map_sel_q;
        tile_sel_d   = tile_sel_q;
        tile_d       = tile_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        pushed_d     = pushed_q;
        accepted_d   = accepted_q;
        oVramRe      = 1'b0;
        oVramAddr    = 13'd0;
        fifo_write   = 1'b0;
        fifo_flush   = 1'b0;
        pushed_next  = pushed_q + 9'd8;

        if (oPixelValid && iPixelReady) begin
            accepted_d = accepted_q + 9'd1;
        end
        if (drop) begin
            disc_cnt_d = disc_cnt_q - 3'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (iStart) begin
                    y_d          = iLy + iScy;
                    col_d        = iScx[7:3];
                    bg_en_d      = iLcdc[LcdcBgEn];
                    map_sel_d    = iLcdc[LcdcMapSel];
                    tile_sel_d   = iLcdc[LcdcTileSel];
                    disc_total_d = iLcdc[LcdcBgEn] ? iScx[2:0] : 3'd0;
                    disc_cnt_d   = iLcdc[LcdcBgEn] ? iScx[2:0] : 3'd0;
                    pushed_d     = 9'd0;
                    accepted_d   = 9'd0;
                    state_d      = iLcdc[LcdcBgEn] ? StMap : StPush;
                end
            end
            StMap: begin
                oVramRe   = 1'b1;
                oVramAddr = map_addr;
                if (iVramAck) begin
                    tile_d  = iVramData;
                    state_d = StLo;
                end
            end
            StLo: begin
                oVramRe   = 1'b1;
                oVramAddr = lo_addr;
                if (iVramAck) begin
                    lo_d    = iVramData;
                    state_d = StHi;
                end
            end
            StHi: begin
                oVramRe   = 1'b1;
                oVramAddr = lo_addr + 13'd1;
                if (iVramAck) begin
                    hi_d    = iVramData;
                    state_d = StPush;
                end
            end
            StPush: begin
                if (fifo_free >= FreeW'(8)) begin
                    fifo_write = 1'b1;
                    col_d      = col_q + 5'd1;
                    pushed_d   = pushed_next;
                    if (pushed_next < LinePix + {6'd0, disc_total_q}) begin
                        state_d = bg_en_q ? StMap : StPush;
                    end else begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (line_end) begin
                    fifo_flush = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q      <= StIdle;
            y_q          <= '0;
            col_q        <= '0;
            disc_total_q <= '0;
            disc_cnt_q   <= '0;
            bg_en_q      <= 1'b0;
            map_sel_q    <= 1'b0;
            tile_sel_q   <= 1'b0;
            tile_q       <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            pushed_q     <= '0;
            accepted_q   <= '0;
        end else begin
            state_q      <= state_d;
            y_q          <= y_d;
            col_q        <= col_d;
            disc_total_q <= disc_total_d;
            disc_cnt_q   <= disc_cnt_d;
            bg_en_q      <= bg_en_d;
            map_sel_q    <= map_sel_d;
            tile_sel_q   <= tile_sel_d;
            tile_q       <= tile_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            pushed_q     <= pushed_d;
            accepted_q   <= accepted_d;
        end
    end

    ppu_pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .iClock (iClock),
        .iReset (iReset),
        .iFlush (fifo_flush),
        .iWrite (fifo_write),
        .iWdata (fifo_wdata),
        .iRead  (fifo_read),
        .oRdata (fifo_rdata),
        .oFull  (unused_fifo_full),
        .oEmpty (fifo_empty),
        .oFree  (fifo_free)
    );

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// Self-checking bench for bg_tile_fetcher: a VRAM responder with random ack
// latency, a golden per-line pixel model feeding a scoreboard queue, and a
// table of line configurations plus hand-written reset/boundary sequences.
module tb_bg_tile_fetcher;

    logic        iClock = 1'b0;
    logic        iReset;
    logic        iStart;
    logic [7:0]  iLy, iScx, iScy, iLcdc, iBgp;
    logic [12:0] oVramAddr;
    logic        oVramRe;
    logic [7:0]  iVramData;
    logic        iVramAck;
    logic [1:0]  oPixel;
    logic        oPixelValid;
    logic        iPixelReady;
    logic        oBusy;
    logic        oLineDone;

    always #5 iClock = ~iClock;

    bg_tile_fetcher dut (
        .iClock      (iClock),
        .iReset      (iReset),
        .iStart      (iStart),
        .iLy         (iLy),
        .iScx        (iScx),
        .iScy        (iScy),
        .iLcdc       (iLcdc),
        .iBgp        (iBgp),
        .oVramAddr   (oVramAddr),
        .oVramRe     (oVramRe),
        .iVramData   (iVramData),
        .iVramAck    (iVramAck),
        .oPixel      (oPixel),
        .oPixelValid (oPixelValid),
        .iPixelReady (iPixelReady),
        .oBusy       (oBusy),
        .oLineDone   (oLineDone)
    );

    typedef struct {
        logic [7:0]  lcdc, scx, scy, ly, bgp;
        int          max_lat;
        bit          stall;
        int          fetches;
        logic [12:0] a0, a1, a2, a3;
    } line_vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  vram [8192];
    logic [1:0]  exp_q [$];
    logic [12:0] rd_log [$];
    int          map_fetches, re_cycles, done_pulses, accepted;
    logic [1:0]  first_pix [8];
    int          max_lat  = 0;
    bit          stall_en = 1'b0;
    bit          hold_en  = 1'b0;
    logic [12:0] hold_addr = 13'd0;
    line_vec_t   vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic line_vec_t mk(input logic [7:0] lcdc, scx, scy, ly, bgp,
                                     input int lat, input bit stall, input int fetches,
                                     input logic [12:0] a0, a1, a2, a3);
        line_vec_t v;
        v.lcdc = lcdc; v.scx = scx; v.scy = scy; v.ly = ly; v.bgp = bgp;
        v.max_lat = lat; v.stall = stall; v.fetches = fetches;
        v.a0 = a0; v.a1 = a1; v.a2 = a2; v.a3 = a3;
        return v;
    endfunction

    // Golden model: pixel i of the line is screen x = (scx + i) mod 256.
    function automatic logic [1:0] gold_pix(input line_vec_t v, input int i);
        logic [7:0] y, x, t, lo, hi, bgp;
        int         map_a, base, a, b;
        logic [1:0] idx;
        bgp = v.bgp;
        if (!v.lcdc[0]) begin
            idx = 2'd0;
        end else begin
            y     = v.ly + v.scy;
            x     = v.scx + 8'(i);
            map_a = (v.lcdc[3] ? 'h1C00 : 'h1800) + int'(y[7:3]) * 32 + int'(x[7:3]);
            t     = vram[map_a];
            base  = v.lcdc[4] ? int'(t) * 16 : 4096 + int'($signed(t)) * 16;
            a     = base + int'(y[2:0]) * 2;
            lo    = vram[a];
            hi    = vram[a + 1];
            b     = 7 - int'(x[2:0]);
            idx   = {hi[b], lo[b]};
        end
`ifdef BG_PALETTE_EN
        return bgp[2*idx +: 2];
`else
        return idx;
`endif
    endfunction

    // VRAM responder: random 0..max_lat wait per request, zero wait allowed.
    initial begin : responder
        int wait_left;
        wait_left = 0;
        iVramAck  = 1'b0;
        iVramData = 8'h00;
        forever begin
            @(posedge iClock);
            #1;
            if (oVramRe && iReset) re_cycles++;
            if (oVramRe && iReset && !(hold_en && oVramAddr == hold_addr) && wait_left == 0) begin
                iVramAck  = 1'b1;
                iVramData = vram[oVramAddr];
                rd_log.push_back(oVramAddr);
                if (oVramAddr >= 13'h1800) map_fetches++;
                wait_left = (max_lat > 0) ? int'($urandom_range(0, max_lat)) : 0;
            end else begin
                iVramAck = 1'b0;
                if (oVramRe && wait_left > 0) wait_left--;
            end
        end
    end

    // Consumer: random ready, scoreboard compare, stall stability, done pulse.
    initial begin : consumer
        bit         prev_stall;
        logic [1:0] prev_pix;
        logic [1:0] e;
        prev_stall  = 1'b0;
        prev_pix    = 2'd0;
        iPixelReady = 1'b0;
        forever begin
            @(negedge iClock);
            if (!iReset) begin
                prev_stall  = 1'b0;
                iPixelReady = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid_held", 32'(oPixelValid), 32'd1);
                    check("stall_pixel_held", 32'(oPixel), 32'(prev_pix));
                end
                iPixelReady = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (oPixelValid && iPixelReady) begin
                    if (exp_q.size() == 0) begin
                        check("extra_pixel", 32'(accepted), 32'(160));
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("pixel[%0d]", accepted), 32'(oPixel), 32'(e));
                    end
                    if (accepted < 8) first_pix[accepted] = oPixel;
                    accepted++;
                end
                prev_stall = oPixelValid && !iPixelReady;
                prev_pix   = oPixel;
                if (oLineDone) begin
                    done_pulses++;
                    check("busy_low_at_done", 32'(oBusy), 32'd0);
                end
            end
        end
    end

    task automatic run_line(input line_vec_t v, input int n);
        bit done;
        iLcdc = v.lcdc; iScx = v.scx; iScy = v.scy; iLy = v.ly; iBgp = v.bgp;
        max_lat = v.max_lat;
        stall_en = v.stall;
        rd_log.delete();
        map_fetches = 0; re_cycles = 0; done_pulses = 0; accepted = 0;
        for (int i = 0; i < 160; i++) exp_q.push_back(gold_pix(v, i));
        @(negedge iClock);
        iStart = 1'b1;
        @(negedge iClock);
        iStart = 1'b0;
        repeat (20) @(negedge iClock);
        check($sformatf("v%0d_busy_mid_line", n), 32'(oBusy), 32'd1);
        // Restart attempt with different settings while busy must be ignored.
        iScx = ~v.scx; iLcdc = 8'h00; iLy = v.ly + 8'd9;
        iStart = 1'b1;
        @(negedge iClock);
        iStart = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 6000 && !done; c++) begin
            @(negedge iClock);
            if (done_pulses > 0) done = 1'b1;
        end
        repeat (5) @(negedge iClock);
        check($sformatf("v%0d_line_done_seen", n), 32'(done), 32'd1);
        check($sformatf("v%0d_done_pulses", n), 32'(done_pulses), 32'd1);
        check($sformatf("v%0d_accepted", n), 32'(accepted), 32'd160);
        check($sformatf("v%0d_scoreboard_left", n), 32'(exp_q.size()), 32'd0);
        check($sformatf("v%0d_busy_after", n), 32'(oBusy), 32'd0);
        check($sformatf("v%0d_tile_fetches", n), 32'(map_fetches), 32'(v.fetches));
        if (!v.lcdc[0]) begin
            check($sformatf("v%0d_re_cycles", n), 32'(re_cycles), 32'd0);
        end else begin
            check($sformatf("v%0d_reads", n), 32'(rd_log.size()), 32'(3 * v.fetches));
            if (rd_log.size() >= 4) begin
                check($sformatf("v%0d_read0", n), 32'(rd_log[0]), 32'(v.a0));
                check($sformatf("v%0d_read1", n), 32'(rd_log[1]), 32'(v.a1));
                check($sformatf("v%0d_read2", n), 32'(rd_log[2]), 32'(v.a2));
                check($sformatf("v%0d_read3", n), 32'(rd_log[3]), 32'(v.a3));
            end
        end
        exp_q.delete();
    endtask

    initial begin : main
        logic [1:0] first_exp [8];
        bit         seen;
        iReset = 1'b0; iStart = 1'b0;
        iLy = 8'h00; iScx = 8'h00; iScy = 8'h00; iLcdc = 8'h00; iBgp = 8'hE4;

        for (int i = 0; i < 8192; i++) vram[i] = 8'($urandom);
        vram[13'h1800] = 8'h01;
        vram[13'h0010] = 8'hF0;
        vram[13'h0011] = 8'hCC;
        vram[13'h1820] = 8'h80;
        vram[13'h181F] = 8'h05;
        vram[13'h1ECB] = 8'h22;

        //            lcdc   scx    scy    ly     bgp   lat st fet  a0       a1       a2       a3
        vecs[0] = mk(8'h91, 8'h00, 8'h00, 8'h00, 8'hE4, 0, 0, 20, 13'h1800, 13'h0010, 13'h0011, 13'h1801);
        vecs[1] = mk(8'h81, 8'h00, 8'h00, 8'h0A, 8'hE4, 1, 0, 20, 13'h1820, 13'h0804, 13'h0805, 13'h1821);
        vecs[2] = mk(8'h91, 8'h03, 8'h08, 8'h00, 8'hE4, 3, 1, 21, 13'h1820, 13'h0800, 13'h0801, 13'h1821);
        vecs[3] = mk(8'h91, 8'hF8, 8'h00, 8'h05, 8'hE4, 3, 1, 20, 13'h181F, 13'h005A, 13'h005B, 13'h1800);
        vecs[4] = mk(8'h80, 8'h13, 8'h00, 8'h00, 8'hE4, 2, 1,  0, 13'h0000, 13'h0000, 13'h0000, 13'h0000);
        vecs[5] = mk(8'h99, 8'h5D, 8'h77, 8'h40, 8'h1B, 3, 1, 21, 13'h1ECB, 13'h022E, 13'h022F, 13'h1ECC);

        repeat (3) @(negedge iClock);
        check("reset_vram_re", 32'(oVramRe), 32'd0);
        check("reset_vram_addr", 32'(oVramAddr), 32'd0);
        check("reset_pixel_valid", 32'(oPixelValid), 32'd0);
        check("reset_pixel", 32'(oPixel), 32'd0);
        check("reset_busy", 32'(oBusy), 32'd0);
        check("reset_line_done", 32'(oLineDone), 32'd0);
        iReset = 1'b1;
        repeat (2) @(negedge iClock);

        for (int n = 0; n < 6; n++) begin
            run_line(vecs[n], n);
            if (n == 0) begin
                first_exp[0] = 2'd3; first_exp[1] = 2'd3; first_exp[2] = 2'd1; first_exp[3] = 2'd1;
                first_exp[4] = 2'd2; first_exp[5] = 2'd2; first_exp[6] = 2'd0; first_exp[7] = 2'd0;
                for (int k = 0; k < 8; k++)
                    check($sformatf("v0_first_pix[%0d]", k), 32'(first_pix[k]), 32'(first_exp[k]));
            end
        end

        // Reset while the HI read of the first tile is outstanding.
        iLcdc = 8'h91; iScx = 8'h00; iScy = 8'h00; iLy = 8'h00; iBgp = 8'hE4;
        max_lat = 0; stall_en = 1'b0;
        hold_en = 1'b1; hold_addr = 13'h0011;
        @(negedge iClock);
        iStart = 1'b1;
        @(negedge iClock);
        iStart = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge iClock);
            if (oVramRe && oVramAddr == 13'h0011) seen = 1'b1;
        end
        check("hi_wait_reached", 32'(seen), 32'd1);
        #2 iReset = 1'b0;
        #1;
        check("midreset_vram_re", 32'(oVramRe), 32'd0);
        check("midreset_vram_addr", 32'(oVramAddr), 32'd0);
        check("midreset_pixel_valid", 32'(oPixelValid), 32'd0);
        check("midreset_pixel", 32'(oPixel), 32'd0);
        check("midreset_busy", 32'(oBusy), 32'd0);
        check("midreset_line_done", 32'(oLineDone), 32'd0);
        @(negedge iClock);
        @(negedge iClock);
        hold_en = 1'b0;
        iReset  = 1'b1;
        repeat (2) @(negedge iClock);
        run_line(vecs[0], 6);
        run_line(vecs[5], 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
